// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

    localparam int         CNT_W         = 16;
    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHK    = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// slave = loader side, master = stream source / memory side.
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic        loader_done;
    logic        load_err;
    cnt_t        words_loaded;

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_waddr, imem_wdata,
        output loader_done, load_err, words_loaded
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_waddr, imem_wdata,
        input  loader_done, load_err, words_loaded
    );

endinterface

// File: rtl/imem_loader_word_packer.sv
// Assembles little-endian bytes into 32-bit words.
// Latency: word_vld pulses the cycle after the 4th byte; no backpressure (caller gates bytes).
module loader_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_byte_vld,
    input  logic [7:0]  i_byte,
    output logic        o_word_vld,
    output logic [31:0] o_word,
    output logic [1:0]  o_idx
);

    logic [1:0]  r_idx;
    logic [23:0] r_buf;
    logic        r_word_vld;
    logic [31:0] r_word;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_idx      <= 2'd0;
            r_buf      <= 24'd0;
            r_word_vld <= 1'b0;
            r_word     <= 32'd0;
        end else begin
            r_word_vld <= 1'b0;
            if (i_clr) begin
                r_idx <= 2'd0;
                r_buf <= 24'd0;
            end else if (i_byte_vld) begin
                // newest byte enters at the top so byte 0 ends up in bits [7:0]
                if (r_idx == 2'd3) begin
                    r_word     <= {i_byte, r_buf};
                    r_word_vld <= 1'b1;
                end else begin
                    r_buf <= {i_byte, r_buf[23:8]};
                end
                r_idx <= r_idx + 2'd1;
            end
        end
    end

    assign o_word_vld = r_word_vld;
    assign o_word     = r_word;
    assign o_idx      = r_idx;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses sync/length/words[/checksum] frames into imem writes (LOADER_CHECKSUM_EN adds checksum).
// Latency: imem_we one cycle after a word's 4th byte; loader_done one cycle after entering DONE.
// Backpressure: in_ready low in DONE/ERR and for the cycle after reset.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          MAX_WORDS      = 1024,
    parameter logic [7:0]  SYNC_BYTE      = DEF_SYNC_BYTE,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave lif
);

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_LEN_LO = ST_LEN_LO;
    localparam logic [2:0] S_LEN_HI = ST_LEN_HI;
    localparam logic [2:0] S_DATA   = ST_DATA;
    localparam logic [2:0] S_DONE   = ST_DONE;
    localparam logic [2:0] S_ERR    = ST_ERR;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHK    = ST_CHK;
    localparam logic [2:0] S_AFTER  = S_CHK;
`else
    localparam logic [2:0] S_AFTER  = S_DONE;
`endif
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [2:0]    r_state, w_nxt;
    logic          r_in_ready;
    cnt_t          r_count, r_words, w_len;
    logic [31:0]   r_addr;
    logic          r_done, r_err;
    logic [TW-1:0] r_tmo;
    logic          w_acc, w_take, w_in_frame, w_timeout, w_sync, w_byte_vld, w_last;
    logic          w_word_vld;
    logic [31:0]   w_word;
    logic [1:0]    w_idx;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    r_chk;
`endif

    assign w_acc  = lif.in_valid & r_in_ready;
`ifdef LOADER_CHECKSUM_EN
    assign w_in_frame = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                        (r_state == S_DATA) || (r_state == S_CHK);
`else
    assign w_in_frame = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) || (r_state == S_DATA);
`endif
    // a byte arriving in the timeout cycle is discarded, never half-consumed
    assign w_timeout  = (TIMEOUT_CYCLES != 0) && w_in_frame && (r_tmo == TW'(TIMEOUT_CYCLES));
    assign w_take     = w_acc & ~w_timeout;
    assign w_sync     = w_take && (r_state == S_IDLE) && (lif.in_data == SYNC_BYTE);
    assign w_len      = {lif.in_data, r_count[7:0]};
    assign w_byte_vld = w_take && (r_state == S_DATA);
    assign w_last     = w_byte_vld && (w_idx == 2'd3) && (r_words == r_count - cnt_t'(1));

    loader_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_sync),
        .i_byte_vld (w_byte_vld),
        .i_byte     (lif.in_data),
        .o_word_vld (w_word_vld),
        .o_word     (w_word),
        .o_idx      (w_idx)
    );

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_sync) w_nxt = S_LEN_LO;
            S_LEN_LO: if (w_take) w_nxt = S_LEN_HI;
            S_LEN_HI: begin
                if (w_take) begin
                    if (w_len == cnt_t'(0))           w_nxt = S_AFTER;
                    else if (int'(w_len) > MAX_WORDS) w_nxt = S_ERR;
                    else                              w_nxt = S_DATA;
                end
            end
            S_DATA:   if (w_last) w_nxt = S_AFTER;
`ifdef LOADER_CHECKSUM_EN
            S_CHK:    if (w_take) w_nxt = (lif.in_data == r_chk) ? S_DONE : S_ERR;
`endif
            S_DONE:   w_nxt = S_DONE;
            S_ERR:    w_nxt = S_IDLE;
            default:  w_nxt = S_IDLE;
        endcase
        if (w_timeout) w_nxt = S_ERR;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_count    <= '0;
            r_words    <= '0;
            r_addr     <= 32'd0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_tmo      <= '0;
        end else begin
            r_state    <= w_nxt;
            r_in_ready <= (w_nxt != S_DONE) && (w_nxt != S_ERR);
            if (r_state == S_LEN_LO && w_take) r_count[7:0]  <= lif.in_data;
            if (r_state == S_LEN_HI && w_take) r_count[15:8] <= lif.in_data;
            if (w_sync) begin
                r_addr  <= BASE_ADDR;
                r_words <= '0;
                r_err   <= 1'b0;
            end else if (w_word_vld) begin
                r_addr  <= r_addr + 32'd4;
                r_words <= r_words + cnt_t'(1);
            end
            if (w_nxt == S_ERR) r_err <= 1'b1;
            r_done <= r_done | (r_state == S_DONE);
            if (!w_in_frame || w_acc) r_tmo <= '0;
            else                      r_tmo <= r_tmo + TW'(1);
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst)            r_chk <= 8'd0;
        else if (w_sync)     r_chk <= 8'd0;
        else if (w_byte_vld) r_chk <= r_chk ^ lif.in_data;
    end
`endif

    assign lif.in_ready     = r_in_ready;
    assign lif.imem_we      = w_word_vld;
    assign lif.imem_waddr   = r_addr;
    assign lif.imem_wdata   = w_word;
    assign lif.loader_done  = r_done;
    assign lif.load_err     = r_err;
    assign lif.words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random frames and gaps checked against a frame-level parser model.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int          MAXW = 1024;
    localparam int          TMO  = 16;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if lif();

    imem_loader #(
        .BASE_ADDR(BASE), .MAX_WORDS(MAXW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .lif(lif)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_we_cyc = -1;
    int done_cyc = -1;
    logic [31:0] mon_addr[$], mon_data[$];
    logic [31:0] exp_addr[$], exp_data[$];
    logic        exp_done, exp_err;
    logic [15:0] exp_wl;
    logic [7:0]  stim[$];
    logic [63:0] got;

    always @(negedge clk) begin
        cyc++;
        if (lif.imem_we) begin
            mon_addr.push_back(lif.imem_waddr);
            mon_data.push_back(lif.imem_wdata);
            last_we_cyc = cyc;
        end
        if (lif.loader_done && done_cyc < 0) done_cyc = cyc;
    end

    // Frame-level reference: scan for sync, read length, take words, optional XOR byte.
    function automatic void model();
        int i = 0;
        int n;
        logic [7:0] x;
        exp_addr.delete(); exp_data.delete();
        exp_done = 1'b0; exp_err = 1'b0; exp_wl = 16'd0;
        while (i < stim.size() && !exp_done) begin
            if (stim[i] != 8'hA5) begin i++; continue; end
            exp_err = 1'b0; exp_wl = 16'd0; x = 8'd0;
            if (i + 2 >= stim.size()) return;
            n = {stim[i+2], stim[i+1]};
            i += 3;
            if (n > MAXW) begin exp_err = 1'b1; continue; end
            for (int k = 0; k < n; k++) begin
                if (i + 3 >= stim.size()) return;
                exp_addr.push_back(BASE + 32'(4 * k));
                exp_data.push_back({stim[i+3], stim[i+2], stim[i+1], stim[i]});
                x = x ^ stim[i] ^ stim[i+1] ^ stim[i+2] ^ stim[i+3];
                exp_wl++;
                i += 4;
            end
            if (CHK_EN) begin
                if (i >= stim.size()) return;
                if (stim[i] == x) exp_done = 1'b1; else exp_err = 1'b1;
                i++;
            end else begin
                exp_done = 1'b1;
            end
        end
    endfunction

    function automatic void add_chk(input int start, input logic [7:0] delta);
        logic [7:0] x = 8'd0;
        for (int k = start + 3; k < stim.size(); k++) x ^= stim[k];
        if (CHK_EN) stim.push_back(x + delta);
    endfunction

    task automatic clear_mon();
        mon_addr.delete(); mon_data.delete();
        last_we_cyc = -1; done_cyc = -1;
    endtask

    task automatic do_reset();
        lif.in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        clear_mon();
    endtask

    task automatic drive(input bit gaps, input int tail);
        bit rdy;
        int t;
        for (int j = 0; j < stim.size(); j++) begin
            if (gaps) repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
            lif.in_valid = 1'b1;
            lif.in_data  = stim[j];
            rdy = 1'b0; t = 0;
            while (!rdy && t < 40) begin
                @(negedge clk); rdy = lif.in_ready;
                @(posedge clk); #1; t++;
            end
            lif.in_valid = 1'b0;
            if (!rdy) begin
                checks++; failures++;
                $display("FAIL drive_ready byte=%0d in_ready=0 required=1", j);
                return;
            end
        end
        repeat (tail) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        lif.in_valid = 1'b0; lif.in_data = 8'h00;
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;
        checks++;
        if ({lif.in_ready, lif.imem_we, lif.loader_done, lif.load_err} !== 4'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b required=0000",
                     {lif.in_ready, lif.imem_we, lif.loader_done, lif.load_err});
        end
        checks++;
        if ({lif.imem_waddr, lif.imem_wdata, lif.words_loaded} !== 80'd0) begin
            failures++;
            $display("FAIL reset_bus got=%h required=0", {lif.imem_waddr, lif.imem_wdata, lif.words_loaded});
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (lif.in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready got=%b required=1", lif.in_ready);
        end
    endtask

    task automatic test_basic();
        for (int g = 0; g < 2; g++) begin
            do_reset();
            stim = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
            add_chk(0, 8'd0);
            model();
            drive(g[0], 6);
            checks++;
            if (mon_data.size() !== exp_data.size()) begin
                failures++; $display("FAIL basic_nwrites got=%0d required=%0d", mon_data.size(), exp_data.size());
            end
            for (int k = 0; k < exp_data.size(); k++) begin
                got = (k < mon_data.size()) ? {mon_addr[k], mon_data[k]} : 64'hx;
                checks++;
                if (got !== {exp_addr[k], exp_data[k]}) begin
                    failures++; $display("FAIL basic_write%0d got=%h required=%h", k, got, {exp_addr[k], exp_data[k]});
                end
            end
            checks++;
            if (mon_data.size() < 2 || {mon_addr[1], mon_data[1]} !== {BASE + 32'd4, 32'h0010_0093}) begin
                failures++; $display("FAIL basic_word1 got_count=%0d required=%h", mon_data.size(), {BASE + 32'd4, 32'h0010_0093});
            end
            checks++;
            if ({lif.loader_done, lif.load_err, lif.words_loaded, lif.in_ready} !== {exp_done, exp_err, exp_wl, 1'b0}) begin
                failures++;
                $display("FAIL basic_status got=%h required=%h",
                         {lif.loader_done, lif.load_err, lif.words_loaded, lif.in_ready}, {exp_done, exp_err, exp_wl, 1'b0});
            end
`ifndef LOADER_CHECKSUM_EN
            checks++;
            if (done_cyc - last_we_cyc !== 1) begin
                failures++; $display("FAIL basic_done_lag got=%0d required=1", done_cyc - last_we_cyc);
            end
`endif
        end
    endtask

    task automatic test_garbage();
        for (int g = 0; g < 2; g++) begin
            do_reset();
            stim = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00};
            repeat (4) stim.push_back(8'($urandom));
            add_chk(3, 8'd0);
            model();
            drive(g[0], 6);
            checks++;
            if (mon_data.size() !== 1 || exp_data.size() !== 1) begin
                failures++; $display("FAIL garbage_nwrites got=%0d required=1", mon_data.size());
            end else begin
                checks++;
                if ({mon_addr[0], mon_data[0]} !== {exp_addr[0], exp_data[0]}) begin
                    failures++; $display("FAIL garbage_write got=%h required=%h", {mon_addr[0], mon_data[0]}, {exp_addr[0], exp_data[0]});
                end
            end
            checks++;
            if ({lif.loader_done, lif.load_err} !== 2'b10) begin
                failures++; $display("FAIL garbage_status got=%b required=10", {lif.loader_done, lif.load_err});
            end
        end
    endtask

    task automatic test_len_err();
        do_reset();
        stim = '{8'hA5, 8'h00, 8'h04};
        drive(0, 4);
        checks++;
        if ({lif.load_err, lif.in_ready} !== 2'b01) begin
            failures++; $display("FAIL len_max_ok got=%b required=01", {lif.load_err, lif.in_ready});
        end
        do_reset();
        stim = '{8'hA5, 8'h01, 8'h04};
        drive(0, 4);
        checks++;
        if ({lif.load_err, lif.loader_done, 32'(mon_data.size())} !== {2'b10, 32'd0}) begin
            failures++;
            $display("FAIL len_over got_err=%b got_done=%b got_writes=%0d required=1,0,0",
                     lif.load_err, lif.loader_done, mon_data.size());
        end
        clear_mon();
        stim = '{8'hA5, 8'h01, 8'h00};
        repeat (4) stim.push_back(8'($urandom));
        add_chk(0, 8'd0);
        model();
        drive(1, 6);
        checks++;
        if (mon_data.size() !== 1 || exp_data.size() !== 1 || mon_data[0] !== exp_data[0] || mon_addr[0] !== BASE) begin
            failures++; $display("FAIL len_recover_write got_count=%0d required_data=%h", mon_data.size(), exp_data[0]);
        end
        checks++;
        if ({lif.loader_done, lif.load_err, lif.words_loaded} !== {exp_done, exp_err, exp_wl}) begin
            failures++;
            $display("FAIL len_recover_status got=%h required=%h",
                     {lif.loader_done, lif.load_err, lif.words_loaded}, {exp_done, exp_err, exp_wl});
        end
        do_reset();
        stim = '{8'hA5, 8'h00, 8'h00};
        add_chk(0, 8'd0);
        drive(0, 4);
        checks++;
        if ({lif.loader_done, lif.load_err, lif.words_loaded, 32'(mon_data.size())} !== {2'b10, 16'd0, 32'd0}) begin
            failures++; $display("FAIL len_zero got_done=%b got_err=%b got_writes=%0d required=1,0,0",
                                 lif.loader_done, lif.load_err, mon_data.size());
        end
    endtask

    task automatic test_timeout();
        do_reset();
        stim = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00};
        drive(0, 0);
        repeat (TMO) begin @(posedge clk); #1; end
        checks++;
        if (lif.load_err !== 1'b0) begin
            failures++; $display("FAIL timeout_early got=%b required=0", lif.load_err);
        end
        @(posedge clk); #1;
        checks++;
        if (lif.load_err !== 1'b1) begin
            failures++; $display("FAIL timeout_err got=%b required=1", lif.load_err);
        end
        repeat (4) begin @(posedge clk); #1; end
        checks++;
        if ({lif.loader_done, lif.words_loaded, 32'(mon_data.size())} !== 49'd0) begin
            failures++; $display("FAIL timeout_nowrite got_done=%b got_writes=%0d required=0,0",
                                 lif.loader_done, mon_data.size());
        end
        stim = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        add_chk(0, 8'd0);
        drive(1, 6);
        checks++;
        if ({lif.loader_done, lif.load_err} !== 2'b10 || mon_data.size() !== 1 || mon_data[0] !== 32'h4433_2211) begin
            failures++; $display("FAIL timeout_recover got_done=%b got_err=%b got_writes=%0d required=1,0,1",
                                 lif.loader_done, lif.load_err, mon_data.size());
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum_err();
        do_reset();
        stim = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        add_chk(0, 8'd1);
        drive(1, 6);
        checks++;
        if (mon_data.size() !== 2) begin
            failures++; $display("FAIL chk_nwrites got=%0d required=2", mon_data.size());
        end
        checks++;
        if ({lif.load_err, lif.loader_done} !== 2'b10) begin
            failures++; $display("FAIL chk_status got=%b required=10", {lif.load_err, lif.loader_done});
        end
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
        stim = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
        drive(0, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({lif.in_ready, lif.imem_we, lif.loader_done, lif.load_err, lif.imem_waddr, lif.imem_wdata, lif.words_loaded} !== 84'd0) begin
            failures++;
            $display("FAIL reset_mid got=%h required=0",
                     {lif.in_ready, lif.imem_we, lif.loader_done, lif.load_err, lif.imem_waddr, lif.imem_wdata, lif.words_loaded});
        end
        rst = 1'b1;
        clear_mon();
        stim = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        add_chk(0, 8'd0);
        drive(0, 6);
        checks++;
        if (mon_data.size() !== 1 || {mon_addr[0], mon_data[0]} !== {BASE, 32'hDEAD_BEEF}) begin
            failures++; $display("FAIL reset_mid_reload got_count=%0d required=%h", mon_data.size(), {BASE, 32'hDEAD_BEEF});
        end
        checks++;
        if ({lif.loader_done, lif.words_loaded} !== {1'b1, 16'd1}) begin
            failures++; $display("FAIL reset_mid_status got=%h required=%h", {lif.loader_done, lif.words_loaded}, {1'b1, 16'd1});
        end
    endtask

    task automatic test_random();
        int start;
        int n;
        logic [7:0] b;
        for (int it = 0; it < 8; it++) begin
            do_reset();
            stim.delete();
            repeat ($urandom_range(0, 3)) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h00;
                stim.push_back(b);
            end
            start = stim.size();
            n = $urandom_range(1, 6);
            stim.push_back(8'hA5); stim.push_back(8'(n)); stim.push_back(8'h00);
            repeat (4 * n) stim.push_back(8'($urandom));
            add_chk(start, 8'd0);
            model();
            drive(it[0], 6);
            checks++;
            if (mon_data.size() !== exp_data.size()) begin
                failures++; $display("FAIL rand%0d_nwrites got=%0d required=%0d", it, mon_data.size(), exp_data.size());
            end
            for (int k = 0; k < exp_data.size(); k++) begin
                got = (k < mon_data.size()) ? {mon_addr[k], mon_data[k]} : 64'hx;
                checks++;
                if (got !== {exp_addr[k], exp_data[k]}) begin
                    failures++; $display("FAIL rand%0d_write%0d got=%h required=%h", it, k, got, {exp_addr[k], exp_data[k]});
                end
            end
            checks++;
            if ({lif.loader_done, lif.load_err, lif.words_loaded} !== {exp_done, exp_err, exp_wl}) begin
                failures++;
                $display("FAIL rand%0d_status got=%h required=%h", it,
                         {lif.loader_done, lif.load_err, lif.words_loaded}, {exp_done, exp_err, exp_wl});
            end
        end
    endtask

    initial begin
        lif.in_valid = 1'b0;
        lif.in_data  = 8'h00;
        test_reset();
        test_basic();
        test_garbage();
        test_len_err();
        test_timeout();
`ifdef LOADER_CHECKSUM_EN
        test_checksum_err();
`endif
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
